// File: rtl/fpu_sequencer_pkg.sv
// fpu_sequencer_pkg: FPU op codes, sequencer state encoding and the
// per-op minimum latency used to mask stale fpu_ready.
package fpu_sequencer_pkg;

    typedef enum logic [1:0] {
        FPU_ADD  = 2'd0,
        FPU_SUB  = 2'd1,
        FPU_MUL  = 2'd2,
        FPU_SQRT = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        POLL = 2'd2,
        RESP = 2'd3
    } seq_state_e;

    function automatic int op_latency(
        input logic [1:0] op,
        input int         mul_lat,
        input int         sqrt_lat
    );
        int lat;
        unique case (op)
            FPU_MUL:  lat = mul_lat;
            FPU_SQRT: lat = sqrt_lat;
            default:  lat = 1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// fpu_req_fifo: synchronous FIFO with async reset, full/empty flags and
// an occupancy count; pointers carry one extra wrap bit.
module fpu_req_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DW-1:0]           wdata_i,
    output logic [DW-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic          do_push, do_pop;

    assign level_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issues queued fixed-point ops to the FPU one at a time
// and returns tagged results, bounding every op with a timeout.
module fpu_sequencer
    import fpu_sequencer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 5,
    parameter int MUL_LAT  = 6,
    parameter int SQRT_LAT = 18,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             busy
);
    localparam int DW = 2 + 2 * WIDTH + TAG_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    seq_state_e       state_q, state_d;
    logic [DW-1:0]    head;
    logic [AW:0]      level;
    logic             fifo_full, fifo_empty;
    logic             issue, capture, retire;
    logic [1:0]       head_op;
    logic [WIDTH-1:0] head_a, head_b;
    logic [TAG_W-1:0] head_tag;
    logic [CW-1:0]    cnt_q, cnt_d, elap_q, elap_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] opa_q, opb_q, res_q;
    logic [TAG_W-1:0] tag_q, rtag_q;
    logic             tmo_q, busy_q;

    assign {head_op, head_a, head_b, head_tag} = head;

    // The in-flight op keeps its slot until its response is taken.
    fpu_req_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (req_valid),
        .pop_i   (retire),
        .wdata_i ({req_op, req_a, req_b, req_tag}),
        .rdata_o (head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        elap_d  = elap_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = WAIT;
                    cnt_d   = CW'(op_latency(head_op, MUL_LAT, SQRT_LAT));
                    elap_d  = '0;
                end
            end
            WAIT: begin
                cnt_d  = cnt_q - CW'(1);
                elap_d = elap_q + CW'(1);
                if (cnt_q <= CW'(1)) state_d = POLL;
            end
            POLL: begin
                elap_d = elap_q + CW'(1);
                if (fpu_ready || elap_q >= CW'(TIMEOUT - 1)) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue     = (state_q == IDLE) && !fifo_empty;
        capture   = (state_q == POLL) && (state_d == RESP);
        retire    = (state_q == RESP) && rsp_ready;
        rsp_valid = (state_q == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            elap_q <= '0;
            op_q   <= FPU_ADD;
            opa_q  <= '0;
            opb_q  <= '0;
            tag_q  <= '0;
            res_q  <= '0;
            rtag_q <= '0;
            tmo_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            elap_q <= elap_d;
            busy_q <= (state_d != IDLE) || (level > (AW+1)'(retire));
            if (issue) begin
                op_q  <= head_op;
                opa_q <= head_a;
                opb_q <= head_b;
                tag_q <= head_tag;
            end
            if (capture) begin
                res_q  <= fpu_ready ? fpu_result : '0;
                rtag_q <= tag_q;
                tmo_q  <= !fpu_ready;
            end
        end
    end

    assign req_ready     = !fifo_full;
    assign fpu_operand_1 = opa_q;
    assign fpu_operand_2 = opb_q;
    assign fpu_operation = op_q;
    assign rsp_result    = res_q;
    assign rsp_tag       = rtag_q;
    assign rsp_timeout   = tmo_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: scoreboard bench with a behavioural Q22.10 FPU model,
// directed timing cases and a randomized traffic phase.
module tb_fpu_sequencer;
    localparam int W    = 32;
    localparam int TW   = 5;
    localparam int FB   = 10;
    localparam int MLAT = 6;
    localparam int SLAT = 18;
    localparam int TMO  = 64;

    typedef enum int {M_READY, M_STALE, M_STUCK_SQRT, M_RANDOM} mode_e;
    typedef struct {
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          tmo;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [W-1:0]  req_a, req_b;
    logic [TW-1:0] req_tag;
    logic [W-1:0]  fpu_operand_1, fpu_operand_2, fpu_result;
    logic [1:0]    fpu_operation;
    logic          fpu_ready;
    logic          rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [W-1:0]  rsp_result;
    logic [TW-1:0] rsp_tag;

    mode_e        mode = M_READY;
    int           age = 0;
    logic         rnd = 1'b0;
    logic [1:0]   last_op = 2'd0;
    logic [W-1:0] last_a = '0, last_b = '0;
    exp_t         sb[$];
    exp_t         mon_e;
    int           nchk = 0, npass = 0, rsp_seen = 0;
    int           k, seen0, hold_bad;
    bit           rdone;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;

    fpu_sequencer #(
        .WIDTH(W), .DEPTH(4), .TAG_W(TW),
        .MUL_LAT(MLAT), .SQRT_LAT(SLAT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag),
        .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
        .fpu_operation(fpu_operation),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] q_ref(
        input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b
    );
        logic signed [63:0] p;
        logic [63:0] x, t;
        logic [31:0] r;
        if (op == 2'd0) return a + b;
        if (op == 2'd1) return a - b;
        if (op == 2'd2) begin
            p = $signed(a) * $signed(b);
            return p[FB+W-1:FB];
        end
        x = {32'd0, a} << FB;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            t = {32'd0, r | (32'd1 << i)};
            if (t * t <= x) r = r | (32'd1 << i);
        end
        return r;
    endfunction

    function automatic exp_t exp_of(
        input logic [1:0] op, input logic [W-1:0] a,
        input logic [W-1:0] b, input logic [TW-1:0] tag
    );
        exp_t e;
        e.tag = tag;
        if (mode == M_STUCK_SQRT && op == 2'd3) begin
            e.res = '0;
            e.tmo = 1'b1;
        end else begin
            e.res = q_ref(op, a, b);
            e.tmo = 1'b0;
        end
        return e;
    endfunction

    // Behavioural FPU: answers from its own arithmetic on the issued lines.
    assign fpu_ready = (mode == M_RANDOM) ? rnd :
                       (mode == M_STUCK_SQRT) ? (fpu_operation != 2'd3) :
                       1'b1;
    assign fpu_result = (mode == M_STALE && age < MLAT) ? 32'hDEAD_BEEF :
                        q_ref(fpu_operation, fpu_operand_1, fpu_operand_2);

    always @(negedge clk) begin
        rnd = 1'($urandom_range(0, 1));
        if ({fpu_operation, fpu_operand_1, fpu_operand_2} !==
            {last_op, last_a, last_b}) begin
            age = 0;
            last_op = fpu_operation;
            last_a = fpu_operand_1;
            last_b = fpu_operand_2;
        end else if (age < 1000) begin
            age++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid) rsp_seen++;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_rsp: got tag %0d, required none",
                         rsp_tag);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_tag", rsp_tag, mon_e.tag);
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_timeout", rsp_timeout, mon_e.tmo);
            end
        end
        if (!reset && req_valid && req_ready)
            sb.push_back(exp_of(req_op, req_a, req_b, req_tag));
    end

    task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag);
        bit ok = 1'b0;
        req_op = op;
        req_a = a;
        req_b = b;
        req_tag = tag;
        req_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        if (!ok) begin
            nchk++;
            $display("FAIL send tag %0d: not accepted, required accept", tag);
        end
    endtask

    task automatic wait_rsp(output int kk);
        kk = 0;
        for (int i = 1; i <= 200 && kk == 0; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) kk = i;
        end
        if (kk == 0) begin
            nchk++;
            $display("FAIL wait_rsp: got no rsp_valid, required within 200");
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((sb.size() != 0 || busy || rsp_valid) && i < 5000) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i >= 5000) begin
            nchk++;
            $display("FAIL wait_idle: got busy, required idle in 5000");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0;
        req_op = 2'd0;
        req_a = '0;
        req_b = '0;
        req_tag = '0;
        rsp_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fpu_op1", fpu_operand_1, 0);
        chk("rst_fpu_op2", fpu_operand_2, 0);
        chk("rst_fpu_operation", fpu_operation, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        mode = M_READY;
        rsp_ready = 1'b1;
        send(2'd0, 32'h600, 32'h900, 5'd3);
        wait_rsp(k);
        chk("add_latency", k, 3);
        wait_idle();

        mode = M_STALE;
        send(2'd2, 32'h600, 32'h600, 5'd7);
        wait_rsp(k);
        chk("mul_latency", k, 8);
        wait_idle();
        mode = M_READY;

        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++)
            send(2'($urandom_range(0, 1)), $urandom, $urandom, 5'(t));
        req_op = 2'd0;
        req_a = 32'h100;
        req_b = 32'h200;
        req_tag = 5'd4;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("req_ready_full", req_ready, 0);
        chk("busy_full", busy, 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(2'd0, 32'h100, 32'h200, 5'd4);
        wait_idle();

        mode = M_STUCK_SQRT;
        send(2'd3, 32'h1000, 32'h0, 5'd9);
        send(2'd0, 32'h400, 32'h400, 5'd10);
        wait_rsp(k);
        chk("sqrt_tmo_in_window", (k + 1 > SLAT + 2) && (k + 1 <= TMO + 2), 1);
        chk("sqrt_tmo_flag", rsp_timeout, 1);
        wait_idle();
        mode = M_READY;

        rsp_ready = 1'b0;
        send(2'd0, 32'h1234, 32'h10, 5'd11);
        send(2'd1, 32'h5000, 32'h300, 5'd12);
        wait_rsp(k);
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_tag !== 5'd11 ||
                rsp_result !== q_ref(2'd0, 32'h1234, 32'h10) ||
                fpu_operation !== 2'd0 ||
                fpu_operand_1 !== 32'h1234 ||
                fpu_operand_2 !== 32'h10)
                hold_bad++;
        end
        chk("rsp_hold_cycles_bad", hold_bad, 0);
        chk("hold_fpu_op2", fpu_operand_2, 32'h10);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();

        send(2'd2, 32'h800, 32'h800, 5'd13);
        send(2'd0, 32'h1, 32'h2, 5'd14);
        send(2'd0, 32'h3, 32'h4, 5'd15);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_fpu_operation", fpu_operation, 0);
        chk("mid_rst_fpu_op1", fpu_operand_1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        seen0 = rsp_seen;
        repeat (30) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_seen, seen0);
        chk("idle_after_reset", busy, 0);

        mode = M_RANDOM;
        rdone = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    r_op = 2'($urandom_range(0, 3));
                    r_a = $urandom;
                    r_b = $urandom;
                    send(r_op, r_a, r_b, 5'(n));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();
        chk("end_busy", busy, 0);
        chk("end_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
